// File: rtl/lsu_bus_pkg.sv
// lsu_bus_pkg: shared load/store bus constants, region map and DMA state encoding
// Used by the core-side request logic, the bus arbiter and lsu_dma_master.
package lsu_bus_pkg;
    localparam logic [3:0]  BMASK_LW    = 4'b0100;
    localparam logic [3:0]  BMASK_SW    = 4'b1010;
    localparam logic [3:0]  BMASK_NONE  = 4'b0000;
    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] LEDR_BASE   = 32'h1000_0000;
    localparam logic [31:0] HEX0_3_BASE = 32'h1000_2000;
    localparam logic [31:0] SW_BASE     = 32'h1001_0000;
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } dma_state_e;
endpackage

// File: rtl/lsu_dma_master.sv
// lsu_dma_master: word-copy DMA initiator on the load/store bus
// Ports: i_clk/i_reset (sync, active high); i_start/i_src/i_dst/i_len start a copy;
// o_busy/o_done/o_err report status; o_req/i_gnt handshake with the arbiter;
// o_addr/o_wdata/o_bmask/o_wren/i_rdata form the bus master port (i_rdata same-cycle).
module lsu_dma_master
    import lsu_bus_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_req,
    input  logic             i_gnt,
    output logic [31:0]      o_addr,
    output logic [31:0]      o_wdata,
    output logic [3:0]       o_bmask,
    output logic             o_wren,
    input  logic [31:0]      i_rdata
);
    dma_state_e       state, state_n;
    logic [31:0]      src_reg, dst_reg, data_reg;
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            src_reg  <= '0;
            dst_reg  <= '0;
            data_reg <= '0;
            cnt      <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && i_start) begin
                src_reg <= i_src;
                dst_reg <= i_dst;
                cnt     <= i_len;
            end
            if (state == S_READ && i_gnt) begin
                data_reg <= i_rdata;
                src_reg  <= src_reg + 32'd4;
            end
            if (state == S_WRITE && i_gnt) begin
                dst_reg <= dst_reg + 32'd4;
                cnt     <= cnt - LEN_W'(1);
            end
        end
    end

    always_comb begin
        state_n = state;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        o_err   = 1'b0;
        o_req   = 1'b0;
        o_addr  = '0;
        o_wdata = '0;
        o_bmask = BMASK_NONE;
        o_wren  = 1'b0;
        case (state)
            S_IDLE: if (i_start)
                state_n = (|i_src[1:0] || |i_dst[1:0]) ? S_ERR :
                          (i_len == '0) ? S_DONE : S_READ;
            S_READ: begin
                o_busy  = 1'b1;
                o_req   = 1'b1;
                o_addr  = src_reg;
                o_bmask = BMASK_LW;
                if (i_gnt) state_n = S_WRITE;
            end
            S_WRITE: begin
                o_busy  = 1'b1;
                o_req   = 1'b1;
                o_addr  = dst_reg;
                o_wdata = data_reg;
                o_bmask = BMASK_SW;
                o_wren  = i_gnt;
                // cnt still holds the pre-decrement count here, so 1 means last word
                if (i_gnt) state_n = (cnt == LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_n = S_IDLE;
            end
            S_ERR: begin
                o_err   = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_dma_master.sv
// tb_lsu_dma_master: self-checking bench with a RAM/IO bus model and write scoreboard
module tb_lsu_dma_master;
    import lsu_bus_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        i_clk = 1'b0;
    logic        i_reset, i_start, i_gnt, mem_init;
    logic [31:0] i_src, i_dst, i_rdata, io_sw, io_ledr;
    logic [15:0] i_len;
    logic        o_busy, o_done, o_err, o_req, o_wren;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_bmask;
    logic [31:0] ram [0:1023];
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int          rd = 0;
    int          nogrant_wr = 0;
    int          checks = 0;
    int          failures = 0;

    lsu_dma_master #(.LEN_W(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_src(i_src),
        .i_dst(i_dst), .i_len(i_len), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_req(o_req), .i_gnt(i_gnt), .o_addr(o_addr),
        .o_wdata(o_wdata), .o_bmask(o_bmask), .o_wren(o_wren), .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    assign i_rdata = (o_addr == SW_BASE) ? io_sw : ram[o_addr[11:2]];

    always @(posedge i_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
            for (int k = 0; k < 4; k++) ram[64+k] = 32'(k + 1) * 32'h1111_1111;
            io_ledr = 32'h0;
        end else if (o_wren) begin
            obs_q.push_back({o_addr, o_wdata});
            if (!i_gnt) nogrant_wr++;
            if (o_addr == LEDR_BASE) io_ledr = o_wdata;
            else ram[o_addr[11:2]] = o_wdata;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        i_start = 1'b1;
        i_src   = s;
        i_dst   = d;
        i_len   = l;
        tick();
        i_start = 1'b0;
        i_src   = 32'h0;
        i_dst   = 32'h0;
        i_len   = 16'h0;
    endtask

    // Runs from cycle c0 until a done/err pulse (bounded by maxc), then one more edge back to IDLE.
    task automatic watch(input int c0, input int maxc, input logic [31:0] stall,
                         output int done_c, output int err_c, output int busy_n, output int req_n);
        done_c = -1;
        err_c  = -1;
        busy_n = 0;
        req_n  = 0;
        for (int c = c0; c <= maxc; c++) begin
            i_gnt = !stall[c];
            #1;
            if (o_busy) busy_n++;
            if (o_req) req_n++;
            if (o_done) done_c = c;
            if (o_err) err_c = c;
            if (o_done || o_err) break;
            tick();
        end
        i_gnt = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [71:0] got;
        got = {o_busy, o_done, o_err, o_req, o_wren, o_addr, o_wdata, o_bmask};
        checks++;
        if (got !== 72'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", got, 72'h0);
        end
    endtask

    task automatic test_basic();
        int dc, ec, bn, rn;
        wr_t e;
        for (int k = 0; k < 4; k++) exp_q.push_back({32'h200 + 32'(4*k), 32'(k + 1) * 32'h1111_1111});
        start(32'h100, 32'h200, 16'd4);
        watch(1, 30, 32'h0, dc, ec, bn, rn);
        checks++; if (dc !== 9) begin failures++; $display("FAIL basic_done_cycle got=%0d want=9", dc); end
        checks++; if (bn !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=8", bn); end
        checks++; if (ec !== -1) begin failures++; $display("FAIL basic_err got=%0d want=-1", ec); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                failures++;
                $display("FAIL basic_write got=%h want=%h", (rd < obs_q.size()) ? obs_q[rd] : 64'h0, e);
            end
            rd++;
        end
        checks++; if (obs_q.size() != rd) begin failures++; $display("FAIL basic_extra_writes got=%0d want=%0d", obs_q.size(), rd); end
        rd = obs_q.size();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ram[128+k] !== 32'(k + 1) * 32'h1111_1111) begin
                failures++;
                $display("FAIL basic_mem[%0d] got=%h want=%h", k, ram[128+k], 32'(k + 1) * 32'h1111_1111);
            end
        end
    endtask

    task automatic test_stalls();
        int dc, ec, bn, rn;
        wr_t e;
        for (int k = 0; k < 4; k++) exp_q.push_back({32'h240 + 32'(4*k), 32'(k + 1) * 32'h1111_1111});
        nogrant_wr = 0;
        start(32'h100, 32'h240, 16'd4);
        watch(1, 30, 32'h0000_004C, dc, ec, bn, rn);
        checks++; if (dc !== 12) begin failures++; $display("FAIL stall_done_cycle got=%0d want=12", dc); end
        checks++; if (nogrant_wr !== 0) begin failures++; $display("FAIL stall_wren_no_gnt got=%0d want=0", nogrant_wr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                failures++;
                $display("FAIL stall_write got=%h want=%h", (rd < obs_q.size()) ? obs_q[rd] : 64'h0, e);
            end
            rd++;
        end
        checks++; if (obs_q.size() != rd) begin failures++; $display("FAIL stall_extra_writes got=%0d want=%0d", obs_q.size(), rd); end
        rd = obs_q.size();
    endtask

    task automatic test_io();
        int dc, ec, bn, rn;
        wr_t e;
        io_sw = 32'h0000_00A5;
        exp_q.push_back({LEDR_BASE, 32'h0000_00A5});
        start(SW_BASE, LEDR_BASE, 16'd1);
        watch(1, 20, 32'h0, dc, ec, bn, rn);
        checks++; if (dc !== 3) begin failures++; $display("FAIL io_done_cycle got=%0d want=3", dc); end
        checks++; if (io_ledr !== 32'h0000_00A5) begin failures++; $display("FAIL io_ledr got=%h want=000000a5", io_ledr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                failures++;
                $display("FAIL io_write got=%h want=%h", (rd < obs_q.size()) ? obs_q[rd] : 64'h0, e);
            end
            rd++;
        end
        checks++; if (obs_q.size() != rd) begin failures++; $display("FAIL io_extra_writes got=%0d want=%0d", obs_q.size(), rd); end
        rd = obs_q.size();
    endtask

    task automatic test_rejects();
        int dc, ec, bn, rn;
        start(32'h102, 32'h200, 16'd4);
        watch(1, 10, 32'h0, dc, ec, bn, rn);
        checks++; if (ec !== 1) begin failures++; $display("FAIL rej_src_err_cycle got=%0d want=1", ec); end
        checks++; if (dc !== -1) begin failures++; $display("FAIL rej_src_done got=%0d want=-1", dc); end
        checks++; if (rn !== 0) begin failures++; $display("FAIL rej_src_req_cycles got=%0d want=0", rn); end
        start(32'h100, 32'h201, 16'd1);
        watch(1, 10, 32'h0, dc, ec, bn, rn);
        checks++; if (ec !== 1) begin failures++; $display("FAIL rej_dst_err_cycle got=%0d want=1", ec); end
        start(32'h100, 32'h200, 16'd0);
        watch(1, 10, 32'h0, dc, ec, bn, rn);
        checks++; if (dc !== 1) begin failures++; $display("FAIL zero_len_done_cycle got=%0d want=1", dc); end
        checks++; if (rn !== 0 || ec !== -1) begin failures++; $display("FAIL zero_len_bus got_req=%0d got_err=%0d want=0,-1", rn, ec); end
        checks++; if (obs_q.size() != rd) begin failures++; $display("FAIL rej_writes got=%0d want=%0d", obs_q.size(), rd); end
        rd = obs_q.size();
        checks++; if (ram[128] !== 32'h1111_1111) begin failures++; $display("FAIL rej_mem got=%h want=11111111", ram[128]); end
    endtask

    task automatic test_reset_mid();
        int dc, ec, bn, rn;
        logic [71:0] got;
        wr_t e;
        exp_q.push_back({32'h300, 32'h1111_1111});
        start(32'h100, 32'h300, 16'd4);
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        got = {o_busy, o_done, o_err, o_req, o_wren, o_addr, o_wdata, o_bmask};
        checks++;
        if (got !== 72'h0) begin failures++; $display("FAIL midreset_outputs got=%h want=%h", got, 72'h0); end
        i_reset = 1'b0;
        checks++; if (ram[193] !== 32'h0) begin failures++; $display("FAIL midreset_word1 got=%h want=00000000", ram[193]); end
        exp_q.push_back({32'h304, 32'h2222_2222});
        start(32'h104, 32'h304, 16'd1);
        watch(1, 20, 32'h0, dc, ec, bn, rn);
        checks++; if (dc !== 3) begin failures++; $display("FAIL midreset_restart_done got=%0d want=3", dc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                failures++;
                $display("FAIL midreset_write got=%h want=%h", (rd < obs_q.size()) ? obs_q[rd] : 64'h0, e);
            end
            rd++;
        end
        checks++; if (obs_q.size() != rd) begin failures++; $display("FAIL midreset_extra_writes got=%0d want=%0d", obs_q.size(), rd); end
        rd = obs_q.size();
    endtask

    task automatic test_start_busy();
        int dc, ec, bn, rn;
        wr_t e;
        for (int k = 0; k < 4; k++) exp_q.push_back({32'h400 + 32'(4*k), 32'(k + 1) * 32'h1111_1111});
        start(32'h100, 32'h400, 16'd4);
        tick();
        tick();
        i_start = 1'b1;
        i_src   = 32'h200;
        i_dst   = 32'h500;
        i_len   = 16'd1;
        tick();
        i_start = 1'b0;
        watch(4, 30, 32'h0, dc, ec, bn, rn);
        checks++; if (dc !== 9) begin failures++; $display("FAIL busy_start_done got=%0d want=9", dc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                failures++;
                $display("FAIL busy_start_write got=%h want=%h", (rd < obs_q.size()) ? obs_q[rd] : 64'h0, e);
            end
            rd++;
        end
        checks++; if (obs_q.size() != rd) begin failures++; $display("FAIL busy_start_extra_writes got=%0d want=%0d", obs_q.size(), rd); end
        rd = obs_q.size();
        checks++; if (ram[320] !== 32'h0) begin failures++; $display("FAIL busy_start_mem500 got=%h want=00000000", ram[320]); end
    endtask

    initial begin
        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_gnt    = 1'b1;
        i_src    = 32'h0;
        i_dst    = 32'h0;
        i_len    = 16'h0;
        io_sw    = 32'h0;
        mem_init = 1'b1;
        tick();
        tick();
        mem_init = 1'b0;
        test_reset();
        i_reset = 1'b0;
        tick();
        test_basic();
        test_stalls();
        test_io();
        test_rejects();
        test_reset_mid();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
